line_centroid_accum: RTL and testbench

- Streaming per-line centroid stage for the CoaXPress acquisition path.
- Consumes one image line of pixels and accumulates two values over pixels at or above a threshold: the hit count and the sum of hit x-coordinates.
- At end of line, drives the hit count into the external reciprocal LUT (N_BITS-bit int -> N_BITS-bit fraction) and multiplies the returned reciprocal by the coordinate sum.
- Emits one rounded, saturated centroid per line on a valid/ready result port.

---
 rtl/line_centroid_pkg.sv | 23 ++
 rtl/centroid_scale.sv | 54 +++++
 rtl/line_centroid_accum.sv | 198 +++++++++++++++++++
 tb/tb_line_centroid_accum.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/line_centroid_pkg.sv
// Shared types and derived constants for the per-line centroid stage.
package line_centroid_pkg;

  // Default geometry of the acquisition path.
  localparam int DEF_N_BITS = 8;
  localparam int DEF_PIX_W  = 8;

  // Coordinate sum and sum*reciprocal product widths for the default geometry.
  localparam int SUM_W  = 2 * DEF_N_BITS;
  localparam int PROD_W = 3 * DEF_N_BITS;

  // Half of one output LSB in the fixed-point product (round-half-up).
  localparam logic [PROD_W-1:0] ROUND_HALF = {{(PROD_W-DEF_N_BITS){1'b0}}, 1'b1, {(DEF_N_BITS-1){1'b0}}};

  // Line processing phases.
  typedef enum logic [1:0] {
    S_ACCUM  = 2'd0,
    S_LOOKUP = 2'd1,
    S_MULT   = 2'd2,
    S_OUT    = 2'd3
  } state_t;

endpackage

// File: rtl/centroid_scale.sv
// Combinational centroid scaling: sum * reciprocal with round-half-up and
// saturation, plus the zero-hit and single-hit special cases.
module centroid_scale
  import line_centroid_pkg::*;
#(
  parameter int N_BITS = DEF_N_BITS
) (
  input  logic [N_BITS-1:0]   count,
  input  logic [2*N_BITS-1:0] sum,
  input  logic [N_BITS-1:0]   recip,
  output logic [N_BITS-1:0]   centroid,
  output logic                no_hit
);

  localparam int SW = 2 * N_BITS;
  localparam int PW = 3 * N_BITS;

  localparam logic [PW-1:0]     ROUND_C  = {{(PW-N_BITS){1'b0}}, 1'b1, {(N_BITS-1){1'b0}}};
  localparam logic [N_BITS-1:0] ZERO_N   = {N_BITS{1'b0}};
  localparam logic [N_BITS-1:0] ONE_N    = {{(N_BITS-1){1'b0}}, 1'b1};
  localparam logic [N_BITS-1:0] CENT_MAX = {N_BITS{1'b1}};

  logic [PW-1:0] prod_s;
  logic [PW-1:0] rounded_s;
  logic [SW-1:0] scaled_s;
  logic          unused_frac_s;

  // The product cannot overflow PW bits: (2^SW-1)*(2^N-1) + 2^(N-1) < 2^PW.
  assign prod_s        = {{N_BITS{1'b0}}, sum} * {{SW{1'b0}}, recip};
  assign rounded_s     = prod_s + ROUND_C;
  assign scaled_s      = rounded_s[PW-1:N_BITS];
  assign unused_frac_s = ^rounded_s[N_BITS-1:0];

  // Select the centroid: no-hit, single-hit bypass, or rounded/saturated mean.
  always_comb begin
    centroid = ZERO_N;
    no_hit   = 1'b0;
    if (count == ZERO_N) begin
      centroid = ZERO_N;
      no_hit   = 1'b1;
    end else if (count == ONE_N) begin
      // The LUT returns all-ones for index 1, so the single hit is passed through.
      centroid = sum[N_BITS-1:0];
      no_hit   = 1'b0;
    end else if (|scaled_s[SW-1:N_BITS]) begin
      centroid = CENT_MAX;
      no_hit   = 1'b0;
    end else begin
      centroid = scaled_s[N_BITS-1:0];
      no_hit   = 1'b0;
    end
  end

endmodule

// File: rtl/line_centroid_accum.sv
// Streaming per-line centroid: counts threshold hits and sums their x positions,
// then scales the sum by an external reciprocal LUT to give one centroid per line.
module line_centroid_accum
  import line_centroid_pkg::*;
#(
  parameter int N_BITS = DEF_N_BITS,
  parameter int PIX_W  = DEF_PIX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PIX_W-1:0]  threshold,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              pix_last,
  output logic [N_BITS-1:0] lut_index,
  input  logic [N_BITS-1:0] lut_reciprocal,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N_BITS-1:0] res_centroid,
  output logic              res_no_hit,
  output logic              res_overflow
);

  localparam int SW = 2 * N_BITS;

  localparam logic [N_BITS-1:0] ZERO_N = {N_BITS{1'b0}};
  localparam logic [N_BITS-1:0] ONE_N  = {{(N_BITS-1){1'b0}}, 1'b1};
  localparam logic [N_BITS-1:0] MAX_N  = {N_BITS{1'b1}};
  localparam logic [SW-1:0]     ZERO_S = {SW{1'b0}};
  localparam logic [PIX_W-1:0]  ZERO_P = {PIX_W{1'b0}};

  state_t            state_r;
  state_t            state_next_s;

  logic [N_BITS-1:0] x_r;
  logic              x_full_r;      // x already at max; further pixels are overflow
  logic [N_BITS-1:0] count_r;
  logic [SW-1:0]     sum_r;
  logic [PIX_W-1:0]  thr_r;
  logic              first_r;       // next accepted pixel starts a line
  logic              overflow_r;
  logic [N_BITS-1:0] recip_r;

  logic [N_BITS-1:0] lut_index_r;
  logic              pix_ready_r;
  logic              res_valid_r;
  logic [N_BITS-1:0] res_centroid_r;
  logic              res_no_hit_r;
  logic              res_overflow_r;

  logic              pix_hs_s;
  logic              res_hs_s;
  logic [PIX_W-1:0]  thr_eff_s;
  logic              hit_s;
  logic [N_BITS-1:0] count_next_s;
  logic [SW-1:0]     sum_next_s;
  logic [N_BITS-1:0] scale_centroid_s;
  logic              scale_no_hit_s;

  assign pix_ready    = pix_ready_r;
  assign lut_index    = lut_index_r;
  assign res_valid    = res_valid_r;
  assign res_centroid = res_centroid_r;
  assign res_no_hit   = res_no_hit_r;
  assign res_overflow = res_overflow_r;

  assign pix_hs_s  = pix_valid & pix_ready_r & (state_r == S_ACCUM);
  assign res_hs_s  = res_valid_r & res_ready;
  // The first pixel of a line compares against the live threshold.
  assign thr_eff_s = first_r ? threshold : thr_r;
  assign hit_s     = pix_hs_s & ~x_full_r & (pix_data >= thr_eff_s);

  // Hit accumulation; count saturates so a fully lit max-length line cannot wrap.
  always_comb begin
    count_next_s = count_r;
    sum_next_s   = sum_r;
    if (hit_s) begin
      if (count_r != MAX_N) begin
        count_next_s = count_r + ONE_N;
      end else begin
        count_next_s = count_r;
      end
      sum_next_s = sum_r + {{N_BITS{1'b0}}, x_r};
    end else begin
      count_next_s = count_r;
      sum_next_s   = sum_r;
    end
  end

  // Next-state logic for the line phases.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_ACCUM: begin
        if (pix_hs_s && pix_last) begin
          state_next_s = S_LOOKUP;
        end else begin
          state_next_s = S_ACCUM;
        end
      end
      S_LOOKUP: state_next_s = S_MULT;
      S_MULT:   state_next_s = S_OUT;
      S_OUT: begin
        if (res_hs_s) begin
          state_next_s = S_ACCUM;
        end else begin
          state_next_s = S_OUT;
        end
      end
      default:  state_next_s = S_ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_ACCUM;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Per-line accumulators: x position, hits, sum, captured threshold, overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r        <= ZERO_N;
      x_full_r   <= 1'b0;
      count_r    <= ZERO_N;
      sum_r      <= ZERO_S;
      thr_r      <= ZERO_P;
      first_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else if (res_hs_s) begin
      x_r        <= ZERO_N;
      x_full_r   <= 1'b0;
      count_r    <= ZERO_N;
      sum_r      <= ZERO_S;
      overflow_r <= 1'b0;
    end else if (pix_hs_s) begin
      count_r <= count_next_s;
      sum_r   <= sum_next_s;
      first_r <= pix_last;
      if (first_r) begin
        thr_r <= threshold;
      end
      if (x_full_r) begin
        overflow_r <= 1'b1;
      end else if (x_r == MAX_N) begin
        x_full_r <= 1'b1;
      end else begin
        x_r <= x_r + ONE_N;
      end
    end
  end

  // Reciprocal capture, LUT index drive, result registers and pixel ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recip_r        <= ZERO_N;
      lut_index_r    <= ZERO_N;
      pix_ready_r    <= 1'b0;
      res_valid_r    <= 1'b0;
      res_centroid_r <= ZERO_N;
      res_no_hit_r   <= 1'b0;
      res_overflow_r <= 1'b0;
    end else begin
      pix_ready_r <= (state_next_s == S_ACCUM);
      if (pix_hs_s && pix_last) begin
        lut_index_r <= count_next_s;
      end else if (res_hs_s) begin
        lut_index_r <= ZERO_N;
      end
      if (state_r == S_LOOKUP) begin
        recip_r <= lut_reciprocal;
      end
      if (state_r == S_MULT) begin
        res_centroid_r <= scale_centroid_s;
        res_no_hit_r   <= scale_no_hit_s;
        res_overflow_r <= overflow_r;
        res_valid_r    <= 1'b1;
      end else if (res_hs_s) begin
        res_valid_r <= 1'b0;
      end
    end
  end

  centroid_scale #(
    .N_BITS (N_BITS)
  ) u_scale (
    .count    (count_r),
    .sum      (sum_r),
    .recip    (recip_r),
    .centroid (scale_centroid_s),
    .no_hit   (scale_no_hit_s)
  );

endmodule

// File: tb/tb_line_centroid_accum.sv
// Directed, table-driven bench for line_centroid_accum with a behavioural
// reciprocal LUT beside the DUT.
module tb_line_centroid_accum;

  logic       clk;
  logic       rst_n;
  logic [7:0] threshold;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] pix_data;
  logic       pix_last;
  logic [7:0] lut_index;
  logic [7:0] lut_reciprocal;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_centroid;
  logic       res_no_hit;
  logic       res_overflow;

  int total;
  int bad;

  typedef struct {
    int len;
    int h0;
    int h1;
    int h2;
    int val;
    int ec;
    int enh;
    int eov;
    int elut;
  } vec_t;

  vec_t vecs[7];

  line_centroid_accum #(.N_BITS(8), .PIX_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .threshold      (threshold),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_data       (pix_data),
    .pix_last       (pix_last),
    .lut_index      (lut_index),
    .lut_reciprocal (lut_reciprocal),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_centroid   (res_centroid),
    .res_no_hit     (res_no_hit),
    .res_overflow   (res_overflow)
  );

  // Reciprocal LUT: floor(256/index), all-ones for index <= 1.
  always_comb begin
    if (lut_index <= 8'd1) begin
      lut_reciprocal = 8'hFF;
    end else begin
      lut_reciprocal = 8'(16'd256 / {8'd0, lut_index});
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one pixel at a negedge, wait (bounded) for ready, return at the next negedge.
  task automatic push_pix(input logic [7:0] d, input logic last);
    int w;
    w = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_last  = last;
    while (!pix_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Send one line, then check latency and the result fields.
  task automatic run_line(input vec_t v, input string tag);
    int n;
    for (int x = 0; x < v.len; x++) begin
      push_pix((x == v.h0 || x == v.h1 || x == v.h2) ? 8'(v.val) : 8'd0, (x == v.len - 1));
      // Later pixels must use the threshold captured on the first one.
      if (x == 0) threshold = 8'd255;
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    threshold = 8'd100;
    n = 1;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 3);
    chk({tag, "_centroid"}, int'(res_centroid), v.ec);
    chk({tag, "_no_hit"}, int'(res_no_hit), v.enh);
    chk({tag, "_overflow"}, int'(res_overflow), v.eov);
    chk({tag, "_lut_index"}, int'(lut_index), v.elut);
    if (res_ready) begin
      @(negedge clk);
      chk({tag, "_valid_drop"}, int'(res_valid), 0);
      chk({tag, "_lut_clear"}, int'(lut_index), 0);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    threshold = 8'd100;
    pix_valid = 1'b0;
    pix_data  = 8'd0;
    pix_last  = 1'b0;
    res_ready = 1'b1;

    //              len  h0   h1   h2  val  ec  nh ov lut
    vecs[0] = '{16,  10,  11,  12, 200,  11, 0, 0, 3};
    vecs[1] = '{16,   2,   5,  -1, 200,   4, 0, 0, 2};
    vecs[2] = '{16,   7,  -1,  -1, 200,   7, 0, 0, 1};
    vecs[3] = '{16,  -1,  -1,  -1, 200,   0, 1, 0, 0};
    vecs[4] = '{ 1,   0,  -1,  -1, 100,   0, 0, 0, 1};
    vecs[5] = '{300, 254, 260, -1, 200, 254, 0, 1, 1};
    vecs[6] = '{20,   3,   4,   9, 255,   5, 0, 0, 3};

    // Reset state.
    #1;
    chk("rst_pix_ready", int'(pix_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_centroid", int'(res_centroid), 0);
    chk("rst_no_hit", int'(res_no_hit), 0);
    chk("rst_overflow", int'(res_overflow), 0);
    chk("rst_lut_index", int'(lut_index), 0);
    repeat (2) @(negedge clk);
    chk("rst_held_ready", int'(pix_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", int'(pix_ready), 1);

    for (int i = 0; i < 7; i++) begin
      run_line(vecs[i], $sformatf("vec%0d", i));
    end

    // Result backpressure: pixels offered while the result is stalled.
    res_ready = 1'b0;
    run_line(vecs[1], "bp");
    pix_valid = 1'b1;
    pix_data  = 8'd200;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_pix_ready", int'(pix_ready), 0);
      chk("bp_res_valid", int'(res_valid), 1);
      chk("bp_centroid", int'(res_centroid), 4);
    end

    // Reset during a pending result drops outputs immediately.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_res_valid", int'(res_valid), 0);
    chk("rst_mid_pix_ready", int'(pix_ready), 0);
    chk("rst_mid_centroid", int'(res_centroid), 0);
    pix_valid = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    res_ready = 1'b1;

    // Partial line with hits, then reset mid-line; the next line must be clean.
    for (int x = 0; x < 4; x++) begin
      push_pix(8'd200, 1'b0);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_line_pix_ready", int'(pix_ready), 0);
    pix_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_line(vecs[0], "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
